uart_program_loader: RTL and testbench

- Boot-time stage upstream of the processor core.
- Receives a program image over a UART serial line and writes 21-bit instruction words into program memory, starting at address 0.
- Holds the core stopped via `cpu_run` until the full image has been written.
- Drives the write port of the instruction store that the program counter later fetches from.

---
 rtl/uart_program_loader_pkg.sv | 13 +
 rtl/uart_program_loader_if.sv | 12 +
 rtl/uart_program_loader_rx_byte.sv | 67 ++++++
 rtl/uart_program_loader.sv | 100 ++++++++++
 tb/tb_uart_program_loader.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/uart_program_loader_pkg.sv
// uart_program_loader_pkg: shared widths, 8N1 framing constants, state encodings and word assembly
package uart_program_loader_pkg;
  localparam int INS_W = 21;
  localparam int ADDR_W = 16;
  localparam int DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [2:0] {LEN_LO, LEN_HI, B0, B1, B2, WRITE, DONE} load_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  function automatic logic [INS_W-1:0] assemble(input logic [4:0] b2, input logic [7:0] b1, input logic [7:0] b0);
    return {b2, b1, b0};
  endfunction
endpackage

// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: serial input and program-memory write port of the loader
interface uart_program_loader_if;
  logic uart_rx;
  logic prog_we;
  logic [uart_program_loader_pkg::ADDR_W-1:0] prog_addr;
  logic [uart_program_loader_pkg::INS_W-1:0] prog_data;
  logic cpu_run;
  logic busy;
  logic frame_err;
  modport master(input uart_rx, output prog_we, prog_addr, prog_data, cpu_run, busy, frame_err);
  modport slave(output uart_rx, input prog_we, prog_addr, prog_data, cpu_run, busy, frame_err);
endinterface

// File: rtl/uart_program_loader_rx_byte.sv
// uart_rx_byte: 8N1 receiver with input synchroniser, glitch rejection and framing check
module uart_rx_byte
  import uart_program_loader_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err_pulse
);
  localparam int CW = $clog2(CLK_DIV);
  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [2:0]    sync_q;
  logic [7:0]    byte_q;
  logic          valid_q;
  logic          ferr_q;
  logic          rx_s;
  // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
  assign rx_s = sync_q[1];
  assign byte_out = byte_q;
  assign byte_valid = valid_q;
  assign frame_err_pulse = ferr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sync_q <= '1;
      byte_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], rx};
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      cnt_q <= cnt_q + 1'b1;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (sync_q[2] && !rx_s) state_q <= RX_START;
        end
        RX_START: if (cnt_q == CW'(CLK_DIV / 2 - 1)) begin
          cnt_q <= '0;
          bit_q <= '0;
          state_q <= (rx_s == START_BIT) ? RX_DATA : RX_IDLE;
        end
        RX_DATA: if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_q <= '0;
          byte_q <= {rx_s, byte_q[7:1]};
          bit_q <= bit_q + 1'b1;
          if (bit_q == 3'(DATA_BITS - 1)) state_q <= RX_STOP;
        end
        RX_STOP: if (cnt_q == CW'(CLK_DIV - 1)) begin
          valid_q <= (rx_s == STOP_BIT);
          ferr_q <= (rx_s != STOP_BIT);
          state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_program_loader.sv
// uart_program_loader: loads a length-prefixed 21-bit program image from UART into program memory
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input logic                  clk,
  input logic                  rst_n,
  uart_program_loader_if.master bus
);
  load_state_e       state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [INS_W-1:0]  data_q;
  logic [7:0]        b0_q;
  logic [7:0]        b1_q;
  logic              we_q;
  logic              run_q;
  logic              busy_q;
  logic              ferr_q;
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              rx_ferr;
  uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk(clk),
    .rst_n(rst_n),
    .rx(bus.uart_rx),
    .byte_out(rx_byte),
    .byte_valid(rx_valid),
    .frame_err_pulse(rx_ferr)
  );
  assign bus.prog_we = we_q;
  assign bus.prog_addr = addr_q;
  assign bus.prog_data = data_q;
  assign bus.cpu_run = run_q;
  assign bus.busy = busy_q;
  assign bus.frame_err = ferr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LEN_LO;
      len_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      we_q <= 1'b0;
      run_q <= 1'b0;
      busy_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      ferr_q <= ferr_q | rx_ferr;
      // a framing error abandons the image; a finished load is never disturbed
      if (rx_ferr && state_q != DONE) begin
        state_q <= LEN_LO;
        addr_q <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state_q)
          LEN_LO: if (rx_valid) begin
            len_q[7:0] <= rx_byte;
            busy_q <= 1'b1;
            state_q <= LEN_HI;
          end
          LEN_HI: if (rx_valid) begin
            len_q[15:8] <= rx_byte;
            if ({rx_byte, len_q[7:0]} == '0) begin
              busy_q <= 1'b0;
              run_q <= 1'b1;
              state_q <= DONE;
            end else state_q <= B0;
          end
          B0: if (rx_valid) begin
            b0_q <= rx_byte;
            state_q <= B1;
          end
          B1: if (rx_valid) begin
            b1_q <= rx_byte;
            state_q <= B2;
          end
          B2: if (rx_valid) begin
            data_q <= assemble(rx_byte[4:0], b1_q, b0_q);
            we_q <= 1'b1;
            state_q <= WRITE;
          end
          WRITE: begin
            addr_q <= addr_q + 1'b1;
            if (addr_q + 1'b1 == len_q) begin
              busy_q <= 1'b0;
              run_q <= 1'b1;
              state_q <= DONE;
            end else state_q <= B0;
          end
          DONE: state_q <= DONE;
          default: state_q <= LEN_LO;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: directed UART image loads with a write scoreboard checking address, data and timing
module tb_uart_program_loader;
  localparam int CLK_DIV = 16;
  // start edge to prog_we: 2 sync + half bit + 9 bits to stop sample + 1 WRITE + 1 counter offset
  localparam int LAT = 2 + CLK_DIV / 2 + 9 * CLK_DIV + 2;
  typedef struct {
    logic [15:0] addr;
    logic [20:0] data;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  uart_program_loader_if bus();
  uart_program_loader #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.prog_we === 1'b1) begin
      if (q.size() == 0) check("unexpected_we", 32'(bus.prog_addr), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = q.pop_front();
        check("we_addr", 32'(bus.prog_addr), 32'(e.addr));
        check("we_data", 32'(bus.prog_data), 32'(e.data));
        check("we_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1, input bit exp_we = 1'b0,
                           input logic [15:0] ea = '0, input logic [20:0] ed = '0);
    @(negedge clk);
    bus.uart_rx = 1'b0;
    if (exp_we) q.push_back('{ea, ed, cyc + LAT});
    for (int i = 0; i < 8; i++) begin
      repeat (CLK_DIV) @(negedge clk);
      bus.uart_rx = b[i];
    end
    repeat (CLK_DIV) @(negedge clk);
    bus.uart_rx = stop;
    repeat (CLK_DIV) @(negedge clk);
    bus.uart_rx = 1'b1;
  endtask
  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask
  task automatic send_ins(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [15:0] ea, input logic [20:0] ed);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2, 1'b1, 1'b1, ea, ed);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"}, 32'(bus.prog_we), 0);
    check({tag, "_addr"}, 32'(bus.prog_addr), 0);
    check({tag, "_data"}, 32'(bus.prog_data), 0);
    check({tag, "_run"}, 32'(bus.cpu_run), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_ferr"}, 32'(bus.frame_err), 0);
  endtask
  initial begin
    bus.uart_rx = 1'b1;
    repeat (100) @(negedge clk);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_run", 32'(bus.cpu_run), 0);
    check("idle_busy", 32'(bus.busy), 0);
    send_byte(8'h02);
    check("len_busy", 32'(bus.busy), 1);
    send_byte(8'h00);
    send_ins(8'h13, 8'h00, 8'h00, 16'd0, 21'h000013);
    check("mid_run", 32'(bus.cpu_run), 0);
    send_ins(8'hFF, 8'hFF, 8'h1F, 16'd1, 21'h1FFFFF);
    check("t2_run", 32'(bus.cpu_run), 1);
    check("t2_busy", 32'(bus.busy), 0);
    check("t2_addr_hold", 32'(bus.prog_addr), 2);
    check("t2_data_hold", 32'(bus.prog_data), 32'h1FFFFF);
    check("t2_pending", 32'(q.size()), 0);
    do_reset();
    send_len(16'h0000);
    check("t3_run", 32'(bus.cpu_run), 1);
    check("t3_busy", 32'(bus.busy), 0);
    send_byte(8'hAA);
    repeat (10) @(negedge clk);
    check("t3_run_after", 32'(bus.cpu_run), 1);
    check("t3_addr", 32'(bus.prog_addr), 0);
    do_reset();
    send_len(16'h0001);
    send_ins(8'h34, 8'h12, 8'hE5, 16'd0, 21'h051234);
    check("t4_run", 32'(bus.cpu_run), 1);
    check("t4_pending", 32'(q.size()), 0);
    do_reset();
    send_len(16'h0001);
    send_byte(8'h55, 1'b0);
    check("t5_ferr", 32'(bus.frame_err), 1);
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_addr", 32'(bus.prog_addr), 0);
    send_len(16'h0001);
    send_ins(8'h07, 8'h00, 8'h00, 16'd0, 21'h000007);
    check("t5_run", 32'(bus.cpu_run), 1);
    check("t5_ferr_sticky", 32'(bus.frame_err), 1);
    do_reset();
    send_byte(8'h01);
    @(negedge clk);
    bus.uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy", 32'(bus.busy), 1);
    check("glitch_ferr", 32'(bus.frame_err), 0);
    send_byte(8'h00);
    send_ins(8'h09, 8'h00, 8'h00, 16'd0, 21'h000009);
    check("glitch_run", 32'(bus.cpu_run), 1);
    do_reset();
    send_len(16'h0003);
    send_ins(8'hAB, 8'hCD, 8'h0E, 16'd0, 21'h0ECDAB);
    send_byte(8'h11);
    @(negedge clk);
    bus.uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    bus.uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_len(16'h0001);
    send_ins(8'h05, 8'h00, 8'h00, 16'd0, 21'h000005);
    check("abort_run", 32'(bus.cpu_run), 1);
    check("abort_addr", 32'(bus.prog_addr), 1);
    repeat (20) @(negedge clk);
    check("final_pending", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
